// File: rtl/mantissa_normalizer.sv
`default_nettype none
// ============================================================================
//  Module   : mantissa_normalizer
//  Purpose  : Post add/subtract normalization stage for IEEE-754 single
//             precision. Accepts the raw 24-bit magnitude (hidden bit at
//             [23]) plus a carry-out bit, exponent and sign. It then produces
//             packed frac/exp/sign fields and the zero/overflow/underflow
//             status flags. A carry is handled with one right shift.
//             Leading zeros are removed with one left shift per cycle.
//  Ports    : clk, rst (async, active-high)
//             in_valid / in_ready             - operand handshake
//             mant_in[23:0], carry_in,
//             exp_in[7:0], sign_in            - operand fields
//             out_valid / out_ready           - result handshake
//             frac_out[22:0], exp_out[7:0],
//             sign_out                        - packed result fields
//             zero_out, overflow, underflow   - status, valid with out_valid
//  Revision : 1.0  initial release
// ============================================================================
module mantissa_normalizer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] mant_in,
   input  logic        carry_in,
   input  logic [7:0]  exp_in,
   input  logic        sign_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [22:0] frac_out,
   output logic [7:0]  exp_out,
   output logic        sign_out,
   output logic        zero_out,
   output logic        overflow,
   output logic        underflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [7:0] EXP_OVF_LIMIT = 8'd254;
   localparam logic [7:0] EXP_INF       = 8'd255;

   state_t      state_q, state_d;

   // Working registers
   logic [23:0] mant_q, mant_d;
   logic [7:0]  exp_q, exp_d;
   logic        sign_q, sign_d;
   logic        carry_q, carry_d;

   // Result registers, loaded on entry to DONE and held until handshake
   logic [22:0] res_frac_q, res_frac_d;
   logic [7:0]  res_exp_q, res_exp_d;
   logic        res_sign_q, res_sign_d;
   logic        res_zero_q, res_zero_d;
   logic        res_ovf_q, res_ovf_d;
   logic        res_unf_q, res_unf_d;

   // One-step left shift shared by CHECK (first shift) and SHIFT
   logic [23:0] shift_mant;
   logic [7:0]  shift_exp;
   logic        shift_exit;

   // Finalisation request: a mantissa/exponent pair to be packed into DONE
   logic        fin_load;
   logic [23:0] fin_mant;
   logic [7:0]  fin_exp;

   assign shift_mant = {mant_q[22:0], 1'b0};
   assign shift_exp  = exp_q - 8'd1;
   // Stop once normalized, or once the exponent reaches the denormal floor
   assign shift_exit = shift_mant[23] || (shift_exp == 8'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mant_q     <= '0;
         exp_q      <= '0;
         sign_q     <= 1'b0;
         carry_q    <= 1'b0;
         res_frac_q <= '0;
         res_exp_q  <= '0;
         res_sign_q <= 1'b0;
         res_zero_q <= 1'b0;
         res_ovf_q  <= 1'b0;
         res_unf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mant_q     <= mant_d;
         exp_q      <= exp_d;
         sign_q     <= sign_d;
         carry_q    <= carry_d;
         res_frac_q <= res_frac_d;
         res_exp_q  <= res_exp_d;
         res_sign_q <= res_sign_d;
         res_zero_q <= res_zero_d;
         res_ovf_q  <= res_ovf_d;
         res_unf_q  <= res_unf_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mant_d     = mant_q;
      exp_d      = exp_q;
      sign_d     = sign_q;
      carry_d    = carry_q;
      res_frac_d = res_frac_q;
      res_exp_d  = res_exp_q;
      res_sign_d = res_sign_q;
      res_zero_d = res_zero_q;
      res_ovf_d  = res_ovf_q;
      res_unf_d  = res_unf_q;
      fin_load   = 1'b0;
      fin_mant   = '0;
      fin_exp    = '0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mant_d  = mant_in;
               exp_d   = exp_in;
               sign_d  = sign_in;
               carry_d = carry_in;
               state_d = S_CHECK;
            end
         end

         S_CHECK: begin
            if ((mant_q == 24'd0) && !carry_q) begin
               // Exact zero is always reported as +0
               state_d    = S_DONE;
               res_frac_d = '0;
               res_exp_d  = '0;
               res_sign_d = 1'b0;
               res_zero_d = 1'b1;
               res_ovf_d  = 1'b0;
               res_unf_d  = 1'b0;
            end else if (carry_q) begin
               if (exp_q >= EXP_OVF_LIMIT) begin
                  // Incremented exponent would reach 255: signed infinity
                  state_d    = S_DONE;
                  res_frac_d = '0;
                  res_exp_d  = EXP_INF;
                  res_sign_d = sign_q;
                  res_zero_d = 1'b0;
                  res_ovf_d  = 1'b1;
                  res_unf_d  = 1'b0;
               end else begin
                  // Bit shifted out of [0] is simply dropped (truncation)
                  fin_load = 1'b1;
                  fin_mant = {1'b1, mant_q[23:1]};
                  fin_exp  = exp_q + 8'd1;
               end
            end else if (mant_q[23] || (exp_q <= 8'd1)) begin
               fin_load = 1'b1;
               fin_mant = mant_q;
               fin_exp  = exp_q;
            end else begin
               mant_d = shift_mant;
               exp_d  = shift_exp;
               if (shift_exit) begin
                  fin_load = 1'b1;
                  fin_mant = shift_mant;
                  fin_exp  = shift_exp;
               end else begin
                  state_d = S_SHIFT;
               end
            end
         end

         S_SHIFT: begin
            mant_d = shift_mant;
            exp_d  = shift_exp;
            if (shift_exit) begin
               fin_load = 1'b1;
               fin_mant = shift_mant;
               fin_exp  = shift_exp;
            end
         end

         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Pack a finite nonzero result; lack of a hidden bit means denormal
      if (fin_load) begin
         state_d    = S_DONE;
         mant_d     = fin_mant;
         exp_d      = fin_exp;
         res_frac_d = fin_mant[22:0];
         res_sign_d = sign_q;
         res_zero_d = 1'b0;
         res_ovf_d  = 1'b0;
         if (fin_mant[23]) begin
            res_exp_d = fin_exp;
            res_unf_d = 1'b0;
         end else begin
            res_exp_d = 8'd0;
            res_unf_d = 1'b1;
         end
      end
   end

   // Outputs are gated by DONE so an async reset clears them immediately
   logic done;
   assign done      = (state_q == S_DONE);
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = done;
   assign frac_out  = done ? res_frac_q : 23'd0;
   assign exp_out   = done ? res_exp_q  : 8'd0;
   assign sign_out  = done & res_sign_q;
   assign zero_out  = done & res_zero_q;
   assign overflow  = done & res_ovf_q;
   assign underflow = done & res_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_mantissa_normalizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mantissa_normalizer
//  Purpose  : Self-checking bench for mantissa_normalizer. A reference model
//             derives each result from leading-zero counting. A single
//             compare process checks the DUT against that model on every
//             cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mantissa_normalizer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] mant_in;
   logic        carry_in;
   logic [7:0]  exp_in;
   logic        sign_in;
   logic        out_valid;
   logic        out_ready;
   logic [22:0] frac_out;
   logic [7:0]  exp_out;
   logic        sign_out;
   logic        zero_out;
   logic        overflow;
   logic        underflow;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      logic [22:0] frac;
      logic [7:0]  e;
      logic        s;
      logic        z;
      logic        o;
      logic        u;
      int          lat;
      int          acc;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   bit   seen = 1'b0;

   mantissa_normalizer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mant_in   (mant_in),
      .carry_in  (carry_in),
      .exp_in    (exp_in),
      .sign_in   (sign_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frac_out  (frac_out),
      .exp_out   (exp_out),
      .sign_out  (sign_out),
      .zero_out  (zero_out),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference: count leading zeros, shift by as many as the exponent allows
   function automatic exp_t model(input logic [23:0] m, input logic c,
                                  input logic [7:0] e, input logic s);
      exp_t r;
      int lz;
      int k;
      int ev;
      logic [23:0] mm;
      r.frac = '0; r.e = '0; r.s = s; r.z = 0; r.o = 0; r.u = 0;
      r.lat = 1; r.acc = 0;
      ev = int'(e);
      if (!c && m == 24'd0) begin
         r.z = 1'b1;
         r.s = 1'b0;
      end else if (c) begin
         if (ev >= 254) begin
            r.e = 8'd255;
            r.o = 1'b1;
         end else begin
            r.frac = m[23:1];
            r.e = 8'(ev + 1);
         end
      end else begin
         lz = 0;
         while (lz < 24 && m[23 - lz] == 1'b0) lz++;
         if (ev <= 1 || lz == 0) k = 0;
         else k = (lz < ev - 1) ? lz : ev - 1;
         mm = m << k;
         r.lat = (k > 1) ? k : 1;
         r.frac = mm[22:0];
         if (mm[23]) r.e = 8'(ev - k);
         else begin
            r.e = 8'd0;
            r.u = 1'b1;
         end
      end
      return r;
   endfunction

   // Single compare process: sampled on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         seen = 1'b0;
      end else begin
         check("in_ready", {31'd0, in_ready}, {31'd0, (q.size() == 0)});
         if (out_valid) begin
            if (q.size() == 0) begin
               check("spurious_out_valid", 32'd1, 32'd0);
            end else begin
               cur = q[0];
               if (!seen) begin
                  seen = 1'b1;
                  check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
               end
               check("frac_out",  {9'd0, frac_out},   {9'd0, cur.frac});
               check("exp_out",   {24'd0, exp_out},   {24'd0, cur.e});
               check("sign_out",  {31'd0, sign_out},  {31'd0, cur.s});
               check("zero_out",  {31'd0, zero_out},  {31'd0, cur.z});
               check("overflow",  {31'd0, overflow},  {31'd0, cur.o});
               check("underflow", {31'd0, underflow}, {31'd0, cur.u});
               if (out_ready) begin
                  void'(q.pop_front());
                  seen = 1'b0;
               end
            end
         end else if (q.size() != 0 && (cyc - q[0].acc) > 30) begin
            check("result_timeout", 32'd0, 32'd1);
            void'(q.pop_front());
            seen = 1'b0;
         end
         if (in_valid && in_ready) begin
            cur = model(mant_in, carry_in, exp_in, sign_in);
            cur.acc = cyc + 1;
            q.push_back(cur);
         end
      end
   end

   task automatic send(input logic [23:0] m, input logic c, input logic [7:0] e,
                       input logic s, input int stall);
      int n;
      @(posedge clk); #1;
      in_valid = 1'b1; mant_in = m; carry_in = c; exp_in = e; sign_in = s;
      @(posedge clk); #1;
      in_valid = 1'b0; mant_in = 24'($urandom); carry_in = 1'($urandom);
      exp_in = 8'($urandom); sign_in = 1'($urandom);
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (stall) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   // Mid-cycle reset pulse; outputs must clear before any clock edge
   task automatic pulse_rst(input string tag);
      #1 rst = 1'b1;
      #1;
      check({tag, "_async_out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_async_exp_out"}, {24'd0, exp_out}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
   endtask

   exp_t pin;
   logic [23:0] rm;
   logic [7:0]  re;
   logic        rc;

   initial begin
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      mant_in = '0; carry_in = 1'b0; exp_in = '0; sign_in = 1'b0;
      #1 rst = 1'b1;
      #2;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_outputs", {frac_out, exp_out, sign_out},  32'd0);
      check("reset_flags", {29'd0, zero_out, overflow, underflow}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);

      // Hand-computed pins on the model itself
      pin = model(24'h400000, 1'b0, 8'd10, 1'b1);
      check("pin_a", {pin.frac, pin.e, pin.s}, {23'h000000, 8'd9, 1'b1});
      check("pin_a_lat", 32'(pin.lat), 32'd1);
      pin = model(24'h000001, 1'b0, 8'd100, 1'b0);
      check("pin_b", {pin.frac, pin.e, pin.s}, {23'h0, 8'd77, 1'b0});
      check("pin_b_lat", 32'(pin.lat), 32'd23);
      pin = model(24'h800000, 1'b1, 8'd127, 1'b0);
      check("pin_c", {pin.frac, pin.e, pin.o}, {23'h400000, 8'd128, 1'b0});
      pin = model(24'h800000, 1'b1, 8'd254, 1'b0);
      check("pin_d", {pin.frac, pin.e, pin.o}, {23'h0, 8'd255, 1'b1});
      pin = model(24'h000100, 1'b0, 8'd5, 1'b0);
      check("pin_e", {pin.frac, pin.e, pin.u}, {23'h001000, 8'd0, 1'b1});
      check("pin_e_lat", 32'(pin.lat), 32'd4);
      pin = model(24'h000000, 1'b0, 8'd33, 1'b1);
      check("pin_f", {pin.frac, pin.e, pin.s, pin.z}, {23'h0, 8'd0, 1'b0, 1'b1});

      // Directed vectors through the DUT
      send(24'h400000, 1'b0, 8'd10,  1'b1, 0);
      send(24'h000001, 1'b0, 8'd100, 1'b0, 0);
      send(24'h800000, 1'b1, 8'd127, 1'b0, 1);
      send(24'h800000, 1'b1, 8'd254, 1'b1, 0);
      send(24'h000100, 1'b0, 8'd5,   1'b0, 0);
      send(24'h000000, 1'b0, 8'd40,  1'b1, 5);
      send(24'h123456, 1'b0, 8'd1,   1'b0, 0);
      send(24'h923456, 1'b0, 8'd0,   1'b1, 0);
      send(24'hffffff, 1'b1, 8'd253, 1'b0, 0);

      // Reset while shifting, then a fresh operand
      @(posedge clk); #1;
      in_valid = 1'b1; mant_in = 24'h000001; carry_in = 1'b0; exp_in = 8'd100; sign_in = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      pulse_rst("rst_shift");
      send(24'h800000, 1'b0, 8'd50, 1'b0, 0);

      // Reset while holding a result in DONE
      @(posedge clk); #1;
      in_valid = 1'b1; mant_in = 24'h400000; carry_in = 1'b0; exp_in = 8'd20; sign_in = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("done_before_rst", {31'd0, out_valid}, 32'd1);
      pulse_rst("rst_done");

      // Randomized operands
      for (int i = 0; i < 200; i++) begin
         rm = 24'($urandom);
         re = 8'($urandom);
         rc = 1'b0;
         case ($urandom_range(0, 5))
            0: ;
            1: rm = rm >> $urandom_range(0, 23);
            2: begin rm = 24'd0; rc = 1'($urandom); end
            3: begin rc = 1'b1; if ($urandom_range(0, 1) == 1) re = 8'($urandom_range(250, 255)); end
            4: begin rm = rm >> $urandom_range(0, 23); re = 8'($urandom_range(0, 6)); end
            default: rm = 24'd1 << $urandom_range(0, 23);
         endcase
         send(rm, rc, re, 1'($urandom), int'($urandom_range(0, 3)));
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
